fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_prefetch_buf.sv | 49 ++++
 rtl/fetch_unit.sv | 189 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-address select codes, the NOP encoding and the
// fetch FSM state encoding.
package cpu_pkg;

  localparam logic [1:0] ADDRESS_SELECT_ALU = 2'b00;
  localparam logic [1:0] ADDRESS_SELECT_PC  = 2'b01;
  localparam logic [1:0] ADDRESS_SELECT_INC = 2'b10;

  localparam logic [31:0] INSTRUCTION_NOP = 32'hE1A0_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_HOLD  = 2'd2,
    FETCH_DRAIN = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_prefetch_buf.sv
// One-entry prefetch buffer holding a fetched word and its address.
// load wins over flush if both are asserted in the same cycle.
module fetch_prefetch_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] load_data,
  input  logic [31:0] load_addr,
  output logic [31:0] data,
  output logic [31:0] addr,
  output logic        valid
);

  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic [31:0] addr_q, addr_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    addr_d  = addr_q;
    if (flush) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      addr_d  = load_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  assign data  = data_q;
  assign addr  = addr_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding read, registered fetch/decode stage.
// Define FETCH_PREFETCH_EN to add a one-entry sequential prefetch buffer.
//
// Memory handshake: mem_req stays high with mem_addr stable until a cycle in
// which mem_ack=1 (mem_rdata valid that cycle); mem_ack while mem_req=0 is ignored.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD     = INSTRUCTION_NOP
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         de_addreg_update,
  input  logic [1:0]   de_addreg_sel,
  input  logic [31:0]  alu_result,
  input  logic [31:0]  reg_pc_value,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ack,
  input  logic [31:0]  mem_rdata,
  output logic [31:0]  fd_instruction,
  output logic         fd_valid,
  output logic [31:0]  fd_pc,
  output fetch_state_e dbg_state
);

  localparam logic [31:0] RESET_ADDR = word_align(RESET_VECTOR);

  fetch_state_e state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  redirect_q, redirect_d;
  logic         fd_valid_q, fd_valid_d;
  logic [31:0]  fd_instr_q, fd_instr_d;
  logic [31:0]  fd_pc_q, fd_pc_d;
  logic         pf_pend_q, pf_pend_d;

  logic         buf_valid, buf_load, buf_flush;
  logic [31:0]  buf_data, buf_addr;
  logic         ack_valid, consume, redirect;
  logic [31:0]  inc_addr, target;

`ifdef FETCH_PREFETCH_EN
  localparam bit PF_EN = 1'b1;

  fetch_prefetch_buf u_prefetch_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .flush     (buf_flush),
    .load_data (mem_rdata),
    .load_addr (addr_q),
    .data      (buf_data),
    .addr      (buf_addr),
    .valid     (buf_valid)
  );
`else
  localparam bit PF_EN = 1'b0;

  logic unused_pf;
  assign buf_valid = 1'b0;
  assign buf_data  = '0;
  assign buf_addr  = '0;
  assign unused_pf = buf_load | buf_flush;
`endif

  // A prefetch is the only request that can be outstanding while in HOLD.
  assign mem_req   = (state_q == FETCH_REQ) || (state_q == FETCH_DRAIN) ||
                     ((state_q == FETCH_HOLD) && pf_pend_q);
  assign ack_valid = mem_ack && mem_req;
  assign consume   = de_addreg_update && fd_valid_q;
  assign inc_addr  = fd_pc_q + 32'd4;

  always_comb begin
    target   = inc_addr;
    redirect = 1'b0;
    case (de_addreg_sel)
      ADDRESS_SELECT_ALU: begin
        target   = word_align(alu_result);
        redirect = 1'b1;
      end
      ADDRESS_SELECT_PC: begin
        target   = word_align(reg_pc_value);
        redirect = 1'b1;
      end
      default: target = inc_addr;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    redirect_d = redirect_q;
    fd_valid_d = fd_valid_q;
    fd_instr_d = fd_instr_q;
    fd_pc_d    = fd_pc_q;
    pf_pend_d  = pf_pend_q;
    buf_load   = 1'b0;
    buf_flush  = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        state_d   = FETCH_REQ;
        addr_d    = RESET_ADDR;
        pf_pend_d = 1'b0;
      end
      FETCH_REQ: begin
        if (ack_valid) begin
          fd_instr_d = mem_rdata;
          fd_pc_d    = addr_q;
          fd_valid_d = 1'b1;
          state_d    = FETCH_HOLD;
        end
      end
      FETCH_HOLD: begin
        if (consume) begin
          if (redirect) begin
            buf_flush  = 1'b1;
            fd_valid_d = 1'b0;
            pf_pend_d  = 1'b0;
            if (pf_pend_q && !ack_valid) begin
              state_d    = FETCH_DRAIN;
              redirect_d = target;
            end else begin
              state_d = FETCH_REQ;
              addr_d  = target;
            end
          end else if (buf_valid) begin
            fd_instr_d = buf_data;
            fd_pc_d    = buf_addr;
            buf_flush  = 1'b1;
          end else if (pf_pend_q && ack_valid) begin
            // Sequential word arrives on the consume edge: forward it directly.
            fd_instr_d = mem_rdata;
            fd_pc_d    = addr_q;
            pf_pend_d  = 1'b0;
          end else if (pf_pend_q) begin
            state_d    = FETCH_REQ;
            fd_valid_d = 1'b0;
            pf_pend_d  = 1'b0;
          end else begin
            state_d    = FETCH_REQ;
            fd_valid_d = 1'b0;
            addr_d     = target;
          end
        end else if (pf_pend_q && ack_valid) begin
          buf_load  = 1'b1;
          pf_pend_d = 1'b0;
        end else if (PF_EN && !pf_pend_q && !buf_valid) begin
          pf_pend_d = 1'b1;
          addr_d    = inc_addr;
        end
      end
      FETCH_DRAIN: begin
        if (ack_valid) begin
          state_d = FETCH_REQ;
          addr_d  = redirect_q;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH_IDLE;
      addr_q     <= RESET_ADDR;
      redirect_q <= RESET_ADDR;
      fd_valid_q <= 1'b0;
      fd_instr_q <= NOP_WORD;
      fd_pc_q    <= RESET_ADDR;
      pf_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      redirect_q <= redirect_d;
      fd_valid_q <= fd_valid_d;
      fd_instr_q <= fd_instr_d;
      fd_pc_q    <= fd_pc_d;
      pf_pend_q  <= pf_pend_d;
    end
  end

  assign mem_addr       = addr_q;
  assign fd_valid       = fd_valid_q;
  assign fd_pc          = fd_pc_q;
  assign fd_instruction = fd_valid_q ? fd_instr_q : NOP_WORD;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// redirect/latency sweep against a transaction-level next-address model.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         de_addreg_update = 1'b0;
  logic [1:0]   de_addreg_sel = 2'b10;
  logic [31:0]  alu_result = '0;
  logic [31:0]  reg_pc_value = '0;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic [31:0]  fd_instruction;
  logic         fd_valid;
  logic [31:0]  fd_pc;
  fetch_state_e dbg_state;

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_pc;

  fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .de_addreg_update (de_addreg_update),
    .de_addreg_sel    (de_addreg_sel),
    .alu_result       (alu_result),
    .reg_pc_value     (reg_pc_value),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata),
    .fd_instruction   (fd_instruction),
    .fd_valid         (fd_valid),
    .fd_pc            (fd_pc),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hE3A0_1005;
    return {a[15:0], a[31:16]} ^ 32'hA5A5_1234;
  endfunction

  function automatic logic [31:0] model_next(input logic [1:0] sel, input logic [31:0] alu,
                                             input logic [31:0] rpc, input logic [31:0] pc);
    logic [31:0] n;
    if (sel == 2'd0)      n = alu;
    else if (sel == 2'd1) n = rpc;
    else                  n = pc + 32'd4;
    return n - (n % 4);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for a request, hold it for lat cycles, then acknowledge with the model word.
  task automatic serve_fetch(input int lat, output logic [31:0] addr, output bit stable,
                             output bit timeout);
    int n = 0;
    timeout = 1'b0;
    stable  = 1'b1;
    addr    = 'x;
    while (mem_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (mem_req !== 1'b1) begin
      timeout = 1'b1;
      return;
    end
    addr = mem_addr;
    for (int i = 0; i < lat; i++) begin
      tick();
      if (mem_req !== 1'b1 || mem_addr !== addr) stable = 1'b0;
    end
    mem_ack   = 1'b1;
    mem_rdata = mem_word(addr);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
  endtask

  task automatic consume(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] rpc);
    de_addreg_update = 1'b1;
    de_addreg_sel    = sel;
    alu_result       = alu;
    reg_pc_value     = rpc;
    tick();
    de_addreg_update = 1'b0;
    alu_result       = $urandom;
    reg_pc_value     = $urandom;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got=%0h exp=0", mem_req); else passes++;
    checks++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr got=%h exp=%h", mem_addr, 32'h0); else passes++;
    checks++; if (fd_valid !== 1'b0) $display("FAIL reset_fd_valid got=%0h exp=0", fd_valid); else passes++;
    checks++; if (fd_instruction !== 32'hE1A0_0000) $display("FAIL reset_fd_instruction got=%h exp=E1A00000", fd_instruction); else passes++;
    checks++; if (fd_pc !== 32'h0) $display("FAIL reset_fd_pc got=%h exp=0", fd_pc); else passes++;
    checks++; if (dbg_state !== FETCH_IDLE) $display("FAIL reset_state got=%0d exp=%0d", dbg_state, FETCH_IDLE); else passes++;
    rst = 1'b0;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) $display("FAIL release_req got=%0h/%h exp=1/00000000", mem_req, mem_addr); else passes++;
  endtask

  task automatic test_first_fetch();
    logic [31:0] a;
    bit st, to;
    serve_fetch(2, a, st, to);
    checks++; if (to) $display("FAIL first_fetch_timeout got=no_req exp=req"); else passes++;
    checks++; if (a !== 32'h0 || !st) $display("FAIL first_fetch_addr got=%h stable=%0d exp=00000000 stable=1", a, st); else passes++;
    checks++; if (fd_valid !== 1'b1) $display("FAIL first_fetch_valid got=%0h exp=1", fd_valid); else passes++;
    checks++; if (fd_instruction !== 32'hE3A0_1005) $display("FAIL first_fetch_instr got=%h exp=E3A01005", fd_instruction); else passes++;
    checks++; if (fd_pc !== 32'h0) $display("FAIL first_fetch_pc got=%h exp=00000000", fd_pc); else passes++;
    cur_pc = 32'h0;
  endtask

  task automatic test_hold_stable();
    int n = $urandom_range(2, 5);
    repeat (n) tick();
    checks++; if (fd_valid !== 1'b1 || fd_pc !== cur_pc || fd_instruction !== mem_word(cur_pc)) $display("FAIL hold_stable got=%0h/%h/%h exp=1/%h/%h", fd_valid, fd_pc, fd_instruction, cur_pc, mem_word(cur_pc)); else passes++;
    checks++; if (mem_req !== 1'b0) $display("FAIL hold_no_prefetch got=%0h exp=0", mem_req); else passes++;
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack   = 1'b0;
    checks++; if (fd_instruction !== mem_word(cur_pc) || fd_pc !== cur_pc) $display("FAIL stray_ack got=%h/%h exp=%h/%h", fd_instruction, fd_pc, mem_word(cur_pc), cur_pc); else passes++;
  endtask

  // Directed consume: check the bubble cycle, serve the fetch, check the new fd_* contents.
  task automatic test_inc();
    logic [1:0]  sels [4] = '{2'd1, 2'd2, 2'd0, 2'd2};
    logic [31:0] vals [4] = '{32'h0000_0010, 32'h0, 32'hFFFF_FFFE, 32'h0};
    logic [31:0] exps [4] = '{32'h0000_0010, 32'h0000_0014, 32'hFFFF_FFFC, 32'h0000_0000};
    logic [31:0] a;
    bit st, to;
    for (int i = 0; i < 4; i++) begin
      consume(sels[i], vals[i], vals[i]);
      checks++; if (mem_req !== 1'b1 || fd_valid !== 1'b0 || fd_instruction !== 32'hE1A0_0000) $display("FAIL inc_bubble_%0d got=%0h/%0h/%h exp=1/0/E1A00000", i, mem_req, fd_valid, fd_instruction); else passes++;
      checks++; if (mem_addr !== exps[i]) $display("FAIL inc_addr_%0d got=%h exp=%h", i, mem_addr, exps[i]); else passes++;
      serve_fetch($urandom_range(0, 3), a, st, to);
      checks++; if (to || !st || fd_pc !== exps[i] || fd_instruction !== mem_word(exps[i])) $display("FAIL inc_fetch_%0d got=%h/%h exp=%h/%h", i, fd_pc, fd_instruction, exps[i], mem_word(exps[i])); else passes++;
      cur_pc = exps[i];
    end
  endtask

  task automatic test_alu_pc();
    logic [31:0] a;
    bit st, to;
    consume(2'd0, 32'h0000_0103, 32'h1234_5678);
    checks++; if (mem_addr !== 32'h0000_0100) $display("FAIL alu_addr got=%h exp=00000100", mem_addr); else passes++;
    serve_fetch(1, a, st, to);
    checks++; if (to || fd_pc !== 32'h0000_0100) $display("FAIL alu_fetch got=%h exp=00000100", fd_pc); else passes++;
    consume(2'd1, 32'h0000_0777, 32'h0000_0040);
    checks++; if (mem_addr !== 32'h0000_0040) $display("FAIL pc_addr got=%h exp=00000040", mem_addr); else passes++;
    serve_fetch(0, a, st, to);
    checks++; if (to || fd_pc !== 32'h0000_0040 || fd_instruction !== mem_word(32'h40)) $display("FAIL pc_fetch got=%h/%h exp=00000040/%h", fd_pc, fd_instruction, mem_word(32'h40)); else passes++;
    cur_pc = 32'h40;
  endtask

  task automatic test_ignore_update();
    logic [31:0] a;
    logic [31:0] e;
    bit st, to;
    e = cur_pc + 32'd4;
    consume(2'd2, 32'h0, 32'h0);
    de_addreg_update = 1'b1;
    de_addreg_sel    = 2'd0;
    alu_result       = 32'h0000_0990;
    repeat (3) tick();
    de_addreg_update = 1'b0;
    checks++; if (mem_addr !== e || mem_req !== 1'b1) $display("FAIL ignore_update_addr got=%h exp=%h", mem_addr, e); else passes++;
    serve_fetch(1, a, st, to);
    checks++; if (to || fd_pc !== e || fd_valid !== 1'b1) $display("FAIL ignore_update_fetch got=%h exp=%h", fd_pc, e); else passes++;
    cur_pc = e;
  endtask

  task automatic test_random();
    logic [31:0] a, e, alu, rpc;
    logic [1:0]  sel;
    bit st, to;
    for (int i = 0; i < 25; i++) begin
      sel = 2'($urandom_range(0, 3));
      alu = $urandom;
      rpc = $urandom;
      repeat ($urandom_range(0, 3)) tick();
      exp_q.push_back(model_next(sel, alu, rpc, cur_pc));
      consume(sel, alu, rpc);
      checks++; if (mem_req !== 1'b1 || fd_valid !== 1'b0) $display("FAIL rand_bubble_%0d got=%0h/%0h exp=1/0", i, mem_req, fd_valid); else passes++;
      serve_fetch($urandom_range(0, 4), a, st, to);
      e = exp_q.pop_front();
      checks++; if (to || !st || a !== e) $display("FAIL rand_req_addr_%0d got=%h exp=%h", i, a, e); else passes++;
      checks++; if (fd_valid !== 1'b1 || fd_pc !== e || fd_instruction !== mem_word(e)) $display("FAIL rand_fd_%0d got=%h/%h exp=%h/%h", i, fd_pc, fd_instruction, e, mem_word(e)); else passes++;
      cur_pc = e;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    bit st, to;
    consume(2'd1, 32'h0, 32'h0000_0020);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h20) $display("FAIL mid_req got=%0h/%h exp=1/00000020", mem_req, mem_addr); else passes++;
    rst = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b0 || fd_valid !== 1'b0 || fd_instruction !== 32'hE1A0_0000) $display("FAIL mid_reset got=%0h/%0h/%h exp=0/0/E1A00000", mem_req, fd_valid, fd_instruction); else passes++;
    checks++; if (mem_addr !== 32'h0 || fd_pc !== 32'h0) $display("FAIL mid_reset_addr got=%h/%h exp=0/0", mem_addr, fd_pc); else passes++;
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_0020;
    tick();
    mem_ack   = 1'b0;
    checks++; if (fd_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0) $display("FAIL late_ack got=%0h/%0h/%h exp=0/1/00000000", fd_valid, mem_req, mem_addr); else passes++;
    serve_fetch(1, a, st, to);
    checks++; if (to || fd_pc !== 32'h0 || fd_instruction !== 32'hE3A0_1005) $display("FAIL refetch got=%h/%h exp=00000000/E3A01005", fd_pc, fd_instruction); else passes++;
    cur_pc = 32'h0;
  endtask

  task automatic test_prefetch_inc();
    logic [31:0] a;
    bit st, to;
    serve_fetch(1, a, st, to);
    checks++; if (to || a !== 32'h4) $display("FAIL pf_req got=%h exp=00000004", a); else passes++;
    checks++; if (fd_valid !== 1'b1 || fd_pc !== 32'h0) $display("FAIL pf_hold got=%0h/%h exp=1/00000000", fd_valid, fd_pc); else passes++;
    consume(2'd2, 32'h0, 32'h0);
    checks++; if (fd_valid !== 1'b1 || fd_pc !== 32'h4 || fd_instruction !== mem_word(32'h4)) $display("FAIL pf_zero_bubble got=%0h/%h/%h exp=1/00000004/%h", fd_valid, fd_pc, fd_instruction, mem_word(32'h4)); else passes++;
    cur_pc = 32'h4;
  endtask

  task automatic test_prefetch_redirect();
    logic [31:0] a;
    bit st, to;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) $display("FAIL pf8_req got=%0h/%h exp=1/00000008", mem_req, mem_addr); else passes++;
    consume(2'd0, 32'h0000_0080, 32'h0);
    checks++; if (dbg_state !== FETCH_DRAIN || mem_req !== 1'b1 || mem_addr !== 32'h8 || fd_valid !== 1'b0) $display("FAIL drain got=%0d/%0h/%h/%0h exp=%0d/1/00000008/0", dbg_state, mem_req, mem_addr, fd_valid, FETCH_DRAIN); else passes++;
    serve_fetch(2, a, st, to);
    checks++; if (to || a !== 32'h8 || mem_req !== 1'b1 || mem_addr !== 32'h80 || fd_valid !== 1'b0) $display("FAIL drain_exit got=%h/%0h/%h exp=00000008/1/00000080", a, mem_req, mem_addr); else passes++;
    serve_fetch(1, a, st, to);
    checks++; if (to || fd_pc !== 32'h80 || fd_instruction !== mem_word(32'h80)) $display("FAIL redirect_fetch got=%h/%h exp=00000080/%h", fd_pc, fd_instruction, mem_word(32'h80)); else passes++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    cur_pc = 32'h0;
    test_reset();
    test_first_fetch();
`ifdef FETCH_PREFETCH_EN
    test_prefetch_inc();
    test_prefetch_redirect();
`else
    test_hold_stable();
    test_inc();
    test_alu_pc();
    test_ignore_update();
    test_random();
    test_reset_mid();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
